// File: rtl/prbs_word_gen.sv
// ---------------------------------------------------------------------------
// prbs_word_gen
//   Multi-polynomial PRBS word generator (PRBS7/15/23/31) with a valid/ready
//   output stream. Each generated word holds WORD_WIDTH fresh LFSR output
//   bits, first-generated bit in the MSB. The seed is runtime-loadable and
//   the polynomial is latched together with the seed.
//
//   Optional feature macro: PRBS_ERR_INJ_EN
//     When defined, adds input err_inj. A pulse arms a one-shot flag that
//     inverts out_data[0] of the next generated word (LFSR state untouched).
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   mode       polynomial select: 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   seed_load  one-cycle pulse: load seed, latch mode, drop pending word
//   seed       seed value, low L bits used (L = active length)
//   en         run request
//   err_inj    (PRBS_ERR_INJ_EN only) arm one-shot LSB inversion
//   out_data   generated word
//   out_valid  out_data is valid
//   out_ready  consumer ready; accept = out_valid && out_ready
//   word_cnt   accepted-word counter, wraps modulo 2^CNT_WIDTH
//   busy       FSM not in IDLE
// ---------------------------------------------------------------------------
module prbs_word_gen #(
  parameter int          WORD_WIDTH   = 5,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [30:0] DEFAULT_SEED = 31'h3552_8C9F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  seed_load,
  input  logic [30:0]           seed,
  input  logic                  en,
`ifdef PRBS_ERR_INJ_EN
  input  logic                  err_inj,
`endif
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t                  state_q, state_d;
  logic [30:0]             lfsr_q;
  logic [1:0]              mode_q;
  logic                    gen;
  logic                    accept;
  logic [30:0]             gen_lfsr;
  logic [WORD_WIDTH-1:0]   gen_word;
  logic                    fb;

  // Mask of the active register length for a polynomial.
  function automatic logic [30:0] len_mask(input logic [1:0] m);
    case (m)
      2'd0:    len_mask = 31'h0000_007F;
      2'd1:    len_mask = 31'h0000_7FFF;
      2'd2:    len_mask = 31'h007F_FFFF;
      default: len_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  // Masked seed; an all-zero state would lock the LFSR, so use all-ones.
  function automatic logic [30:0] seed_fix(input logic [30:0] s, input logic [1:0] m);
    logic [30:0] masked;
    masked = s & len_mask(m);
    seed_fix = (masked == 31'd0) ? len_mask(m) : masked;
  endfunction

  // Fibonacci feedback: s[a-1] ^ s[b-1] for taps (a,b).
  function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    lfsr_fb = s[6]  ^ s[5];
      2'd1:    lfsr_fb = s[14] ^ s[13];
      2'd2:    lfsr_fb = s[22] ^ s[17];
      default: lfsr_fb = s[30] ^ s[27];
    endcase
  endfunction

  // WORD_WIDTH unrolled LFSR steps; each step's feedback bit is the output bit.
  always_comb begin
    gen_lfsr = lfsr_q;
    gen_word = '0;
    fb       = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      fb                         = lfsr_fb(gen_lfsr, mode_q);
      gen_word[WORD_WIDTH-1-i]   = fb;
      gen_lfsr                   = {gen_lfsr[29:0], fb} & len_mask(mode_q);
    end
  end

  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = out_valid && out_ready;

  // Next state; seed_load and rst override this in the register process.
  always_comb begin
    state_d = state_q;
    gen     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          gen     = 1'b1;
          state_d = RUN;
        end
      end
      RUN, STALL: begin
        if (accept) begin
          if (en) begin
            gen     = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PRBS_ERR_INJ_EN
  logic                  inj_q;
  logic [WORD_WIDTH-1:0] word_out;

  always_comb begin
    word_out    = gen_word;
    word_out[0] = gen_word[0] ^ inj_q;
  end

  // One-shot flag: consumed by the next registered word, re-armed by a pulse.
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= (inj_q && !gen) || err_inj;
    end
  end
`else
  logic [WORD_WIDTH-1:0] word_out;
  assign word_out = gen_word;
`endif

  // State register / output word / counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= seed_fix(DEFAULT_SEED, 2'd3);
      mode_q   <= 2'd3;
      out_data <= '0;
      word_cnt <= '0;
    end else if (seed_load) begin
      state_q  <= IDLE;
      lfsr_q   <= seed_fix(seed, mode);
      mode_q   <= mode;
      word_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (gen) begin
        lfsr_q   <= gen_lfsr;
        out_data <= word_out;
      end
      if (accept) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_word_gen.sv
module tb_prbs_word_gen;
  localparam int WW = 8;
  localparam int CW = 4;
  localparam logic [30:0] DSEED = 31'h3552_8C9F;

  logic          clk = 1'b0;
  logic          rst, seed_load, en, out_ready;
  logic [1:0]    mode;
  logic [30:0]   seed;
  logic [WW-1:0] out_data;
  logic          out_valid, busy;
  logic [CW-1:0] word_cnt;
`ifdef PRBS_ERR_INJ_EN
  logic          err_inj;
`endif

  prbs_word_gen #(.WORD_WIDTH(WW), .CNT_WIDTH(CW), .DEFAULT_SEED(DSEED)) dut (
    .clk(clk), .rst(rst), .mode(mode), .seed_load(seed_load), .seed(seed), .en(en),
`ifdef PRBS_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_cnt(word_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [30:0]   m_s;
  logic [1:0]    m_mode;
  int            exp_cnt;
  logic [WW-1:0] last_w;

  typedef struct {
    logic [1:0]    md;
    logic [30:0]   sd;
    logic [WW-1:0] w0;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_len(input logic [1:0] md);
    case (md)
      2'd0:    return 7;
      2'd1:    return 15;
      2'd2:    return 23;
      default: return 31;
    endcase
  endfunction

  function automatic logic [30:0] m_seed(input logic [30:0] s, input logic [1:0] md);
    logic [30:0] mask, v;
    mask = 31'h7FFF_FFFF >> (31 - m_len(md));
    v = s & mask;
    return (v == 0) ? mask : v;
  endfunction

  // Reference LFSR: steps the bench state one bit at a time.
  task automatic m_next(output logic [WW-1:0] w);
    int len, tb;
    logic nb;
    logic [30:0] mask;
    len = m_len(m_mode);
    case (m_mode)
      2'd0:    tb = 6;
      2'd1:    tb = 14;
      2'd2:    tb = 18;
      default: tb = 28;
    endcase
    mask = 31'h7FFF_FFFF >> (31 - len);
    w = '0;
    for (int i = 0; i < WW; i++) begin
      nb  = m_s[len-1] ^ m_s[tb-1];
      w   = {w[WW-2:0], nb};
      m_s = ((m_s << 1) | {30'd0, nb}) & mask;
    end
  endtask

  task automatic do_seed(input logic [1:0] md, input logic [30:0] sd);
    en = 1'b0; out_ready = 1'b0;
    seed_load = 1'b1; mode = md; seed = sd;
    tick();
    seed_load = 1'b0;
    m_s = m_seed(sd, md); m_mode = md; exp_cnt = 0;
    chk("seed_valid", {31'd0, out_valid}, 0);
    chk("seed_cnt", {28'd0, word_cnt}, 0);
    chk("seed_busy", {31'd0, busy}, 0);
  endtask

  // First word from IDLE: valid one edge after en.
  task automatic start_first();
    en = 1'b1; out_ready = 1'b1;
    tick();
    m_next(last_w);
    chk("first_valid", {31'd0, out_valid}, 1);
    chk("first_data", {24'd0, out_data}, {24'd0, last_w});
  endtask

  task automatic run_stream(input int n);
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      exp_cnt++;
      m_next(last_w);
      chk("stream_data", {24'd0, out_data}, {24'd0, last_w});
      chk("stream_cnt", {28'd0, word_cnt}, 32'(exp_cnt % 16));
      chk("stream_valid", {31'd0, out_valid}, 1);
    end
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; en = 1'b0; out_ready = 1'b0; mode = 2'd0; seed = '0;
`ifdef PRBS_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    vt[0] = '{2'd0, 31'h0000_007F, 8'h02};
    vt[1] = '{2'd0, 31'h0000_0000, 8'h02};
    vt[2] = '{2'd0, 31'h0000_0001, 8'h06};
    vt[3] = '{2'd0, 31'h7FFF_FF80, 8'h02};
    vt[4] = '{2'd1, 31'h0000_6000, 8'h40};
    vt[5] = '{2'd1, 31'h0000_0000, 8'h00};
    vt[6] = '{2'd2, 31'h0040_0000, 8'h80};
    vt[7] = '{2'd3, 31'h4800_0000, 8'h10};

    // Reset values, then default-seed PRBS31 stream
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", {28'd0, word_cnt}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    m_s = m_seed(DSEED, 2'd3); m_mode = 2'd3; exp_cnt = 0;
    tick();
    chk("idle_hold_valid", {31'd0, out_valid}, 0);
    start_first();
    run_stream(20);

    // Backpressure: five stalled cycles, en dropped mid-stall
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) en = 1'b0;
      tick();
      chk("stall_data", {24'd0, out_data}, {24'd0, last_w});
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_cnt", {28'd0, word_cnt}, 32'(exp_cnt % 16));
    end
    run_stream(4);

    // Table: first word after seed_load, then one accepted follow-on word
    for (int k = 0; k < 8; k++) begin
      do_seed(vt[k].md, vt[k].sd);
      en = 1'b1; out_ready = 1'b0;
      tick();
      chk("tbl_valid", {31'd0, out_valid}, 1);
      chk("tbl_w0", {24'd0, out_data}, {24'd0, vt[k].w0});
      m_next(last_w);
      run_stream(1);
    end

    // PRBS7 period 127: word 128 equals word 1; mode input ignored mid-run
    do_seed(2'd0, 31'h7F);
    start_first();
    mode = 2'd3;
    run_stream(127);
    chk("prbs7_period", {24'd0, out_data}, 32'h02);

    // Counter wrap: 17 accepts on a 4-bit counter
    do_seed(2'd3, 31'h5);
    start_first();
    run_stream(17);
    chk("cnt_wrap", {28'd0, word_cnt}, 1);

    // Accept with en=0 goes idle; restart continues the sequence
    en = 1'b0; out_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("acc_idle_valid", {31'd0, out_valid}, 0);
    chk("acc_idle_busy", {31'd0, busy}, 0);
    chk("acc_idle_cnt", {28'd0, word_cnt}, 2);
    start_first();
    run_stream(2);

    // seed_load while stalled: held word dropped and not counted
    out_ready = 1'b0; en = 1'b1;
    tick();
    chk("pre_seed_stall", {31'd0, out_valid}, 1);
    do_seed(2'd1, 31'h0);
    start_first();
    chk("seed0_w0", {24'd0, out_data}, 32'h00);
    run_stream(3);

    // Reset mid-stream
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_cnt", {28'd0, word_cnt}, 0);
    chk("mid_rst_data", {24'd0, out_data}, 0);
    m_s = m_seed(DSEED, 2'd3); m_mode = 2'd3; exp_cnt = 0;
    start_first();
    run_stream(2);

`ifdef PRBS_ERR_INJ_EN
    do_seed(2'd0, 31'h7F);
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    en = 1'b1; out_ready = 1'b1;
    tick();
    m_next(last_w);
    chk("inj_word", {24'd0, out_data}, {24'd0, last_w ^ 8'h01});
    run_stream(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
